iomem_spi_master: RTL and testbench

Register-mapped SPI master that sits on the SoC `iomem` bus as a responder, completing the valid/ready transactions the CPU issues for addresses above the on-chip RAM, flash-controller and UART window. Software programs a clock divider and chip-select, writes a byte to start a mode-0 SPI transfer, and reads the received byte back. It drives the board-level `spi_ck`/`spi_mosi`/`spi_cs` pins and samples `spi_miso`.

---
 rtl/iomem_spi_master_pkg.sv | 24 ++
 rtl/iomem_spi_master_if.sv | 19 +
 rtl/iomem_spi_master_engine.sv | 114 +++++++++++
 rtl/iomem_spi_master.sv | 98 +++++++++
 tb/tb_iomem_spi_master.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/iomem_spi_master_pkg.sv
// Shared constants for the iomem SPI master: register offsets, CTRL field
// positions and the shift-engine state encoding.
package iomem_spi_pkg;

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_DATA   = 2'd1,
    REG_STATUS = 2'd2,
    REG_RSVD   = 2'd3
  } reg_off_e;

  localparam int CTRL_DIV_LSB   = 0;
  localparam int CTRL_DIV_W     = 8;
  localparam int CTRL_CS_EN_BIT = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOW  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;

  function automatic logic [31:0] pack_ctrl(input logic [7:0] div, input logic cs_en);
    return {23'h0, cs_en, div};
  endfunction

endpackage

// File: rtl/iomem_spi_master_if.sv
// iomem valid/ready bus as seen by one responder; the CPU side is the master.
interface iomem_spi_master_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    input  iomem_ready, iomem_rdata
  );

  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    output iomem_ready, iomem_rdata
  );
endinterface

// File: rtl/iomem_spi_master_engine.sv
// Mode-0 SPI byte engine: half-period counter, bit counter and shift register.
// The division ratio is re-sampled at every half-period load.
module spi_shift_engine
  import iomem_spi_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] din,
  input  logic [7:0] div,
  output logic       busy,
  output logic       done,
  output logic [7:0] dout,
  output logic       spi_ck,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  logic [1:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] period_q, period_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic       sample_q, sample_d;
  logic       ck_q, ck_d;
  logic       mosi_q, mosi_d;
  logic       half_end;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    sample_d = sample_q;
    ck_d     = ck_q;
    mosi_d   = mosi_q;
    done     = 1'b0;
    half_end = (cnt_q == period_q);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_LOW;
          cnt_d    = 8'd0;
          period_d = div;
          bit_d    = 3'd0;
          shift_d  = din;
          mosi_d   = din[7];
          ck_d     = 1'b0;
        end
      end
      ST_LOW: begin
        if (half_end) begin
          state_d  = ST_HIGH;
          ck_d     = 1'b1;
          sample_d = spi_miso;
          cnt_d    = 8'd0;
          period_d = div;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_HIGH: begin
        if (half_end) begin
          ck_d     = 1'b0;
          cnt_d    = 8'd0;
          period_d = div;
          if (bit_q == 3'd7) begin
            state_d = ST_IDLE;
            done    = 1'b1;
          end else begin
            // MISO is held aside until the fall so the unsent LSBs survive.
            state_d = ST_LOW;
            shift_d = {shift_q[6:0], sample_q};
            mosi_d  = shift_q[6];
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 8'd0;
      period_q <= 8'd0;
      bit_q    <= 3'd0;
      shift_q  <= 8'd0;
      sample_q <= 1'b0;
      ck_q     <= 1'b0;
      mosi_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      sample_q <= sample_d;
      ck_q     <= ck_d;
      mosi_q   <= mosi_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign dout     = {shift_q[6:0], sample_q};
  assign spi_ck   = ck_q;
  assign spi_mosi = mosi_q;

endmodule

// File: rtl/iomem_spi_master.sv
// Register-mapped SPI master on the iomem bus: address decode, CTRL/rx
// registers, one-cycle ready pulse and read mux around the shift engine.
module iomem_spi_master
  import iomem_spi_pkg::*;
#(
  parameter logic [7:0] ADDR_HI   = 8'h03,
  parameter logic [7:0] DIV_RESET = 8'd1
) (
  input  logic              clk,
  input  logic              reset,
  iomem_spi_master_if.slave bus,
  output logic              spi_ck,
  output logic              spi_mosi,
  output logic              spi_cs,
  input  logic              spi_miso
);

  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic [7:0]  div_q, div_d;
  logic        cs_en_q, cs_en_d;
  logic [7:0]  rx_q, rx_d;
  logic        sel, is_write, stall, accept, start;
  logic        busy, done;
  logic [7:0]  dout;
  logic [31:0] rd_mux;
  reg_off_e    off;

  always_comb begin
    sel      = bus.iomem_valid && (bus.iomem_addr[31:24] == ADDR_HI);
    off      = reg_off_e'(bus.iomem_addr[3:2]);
    is_write = |bus.iomem_wstrb;
    // A DATA write waits for the engine; everything else completes at once.
    stall    = (off == REG_DATA) && is_write && busy;
    accept   = sel && !ready_q && !stall;
    start    = accept && (off == REG_DATA) && bus.iomem_wstrb[0];
  end

  always_comb begin
    case (off)
      REG_CTRL:   rd_mux = pack_ctrl(div_q, cs_en_q);
      REG_DATA:   rd_mux = {24'h0, rx_q};
      REG_STATUS: rd_mux = {31'h0, busy};
      default:    rd_mux = 32'h0;
    endcase
  end

  always_comb begin
    ready_d = accept;
    rdata_d = (accept && !is_write) ? rd_mux : 32'h0;
    div_d   = div_q;
    cs_en_d = cs_en_q;
    rx_d    = done ? dout : rx_q;
    if (accept && is_write && (off == REG_CTRL)) begin
      if (bus.iomem_wstrb[0]) div_d = bus.iomem_wdata[CTRL_DIV_LSB +: CTRL_DIV_W];
      if (bus.iomem_wstrb[1]) cs_en_d = bus.iomem_wdata[CTRL_CS_EN_BIT];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q <= 1'b0;
      rdata_q <= 32'h0;
      div_q   <= DIV_RESET;
      cs_en_q <= 1'b0;
      rx_q    <= 8'h0;
    end else begin
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      div_q   <= div_d;
      cs_en_q <= cs_en_d;
      rx_q    <= rx_d;
    end
  end

  spi_shift_engine u_engine (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .din      (bus.iomem_wdata[7:0]),
    .div      (div_q),
    .busy     (busy),
    .done     (done),
    .dout     (dout),
    .spi_ck   (spi_ck),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  assign bus.iomem_ready = ready_q;
  assign bus.iomem_rdata = rdata_q;
  assign spi_cs          = ~cs_en_q;

  logic unused_bits;
  assign unused_bits = &{1'b0, bus.iomem_addr[23:4], bus.iomem_addr[1:0],
                         bus.iomem_wdata[31:9], bus.iomem_wstrb[3:2]};

endmodule

// File: tb/tb_iomem_spi_master.sv
// Scoreboard bench for iomem_spi_master: bus accesses queue their expected read
// data, a monitor checks each ready pulse, and a pin monitor logs SPI clock rises.
module tb_iomem_spi_master;

  localparam logic [31:0] A_CTRL   = 32'h0300_0000;
  localparam logic [31:0] A_DATA   = 32'h0300_0004;
  localparam logic [31:0] A_STATUS = 32'h0300_0008;
  localparam logic [31:0] A_RSVD   = 32'h0300_000C;
  localparam logic [31:0] A_OTHER  = 32'h0400_0000;

  typedef struct {
    bit          check_data;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic reset;
  logic spi_ck, spi_mosi, spi_cs, spi_miso;
  int   errors = 0;
  int   checks = 0;
  int   cycle = 0;

  exp_t exp_q[$];
  int   rise_cycle[$];
  bit   rise_mosi[$];
  int   busy_fall_cycle = -1;
  int   last_ready_cycle = -1;
  bit   prev_ready = 0;
  bit   prev_ck = 0;
  bit   prev_busy = 0;

  iomem_spi_master_if bus ();

  iomem_spi_master #(.ADDR_HI(8'h03), .DIV_RESET(8'd1)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .spi_ck   (spi_ck),
    .spi_mosi (spi_mosi),
    .spi_cs   (spi_cs),
    .spi_miso (spi_miso)
  );

  assign spi_miso = spi_mosi;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Scoreboard monitor: every ready pulse pops one expected response.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prev_ready = 1'b0;
    end else begin
      if (bus.iomem_ready) begin
        checkOutput("ready_single_cycle", {31'h0, prev_ready}, 32'h0);
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_ready", 32'h1, 32'h0);
        end else if (!prev_ready) begin
          e = exp_q.pop_front();
          if (e.check_data) checkOutput("rdata", bus.iomem_rdata, e.data);
        end
      end
      prev_ready = bus.iomem_ready;
    end
  end

  always @(negedge clk) begin
    if (spi_ck && !prev_ck) begin
      rise_cycle.push_back(cycle);
      rise_mosi.push_back(spi_mosi);
    end
    if (prev_busy && !dut.busy) busy_fall_cycle = cycle;
    if (bus.iomem_ready) last_ready_cycle = cycle;
    prev_ck   = spi_ck;
    prev_busy = dut.busy;
  end

  task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] wstrb,
                               input logic [31:0] wdata, input bit check_data,
                               input logic [31:0] exp_data, input bit expect_ready,
                               input int max_wait, output int wait_cycles);
    exp_t e;
    bit   got;
    if (expect_ready) begin
      e.check_data = check_data;
      e.data       = exp_data;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.iomem_valid = 1'b1;
    bus.iomem_addr  = addr;
    bus.iomem_wstrb = wstrb;
    bus.iomem_wdata = wdata;
    wait_cycles = 0;
    got = 1'b0;
    while (wait_cycles < max_wait) begin
      @(negedge clk);
      if (bus.iomem_ready) begin
        got = 1'b1;
        break;
      end
      wait_cycles++;
    end
    if (expect_ready) begin
      checkOutput($sformatf("ready_seen_%08h", addr), {31'h0, got}, 32'h1);
      if (!got) void'(exp_q.pop_back());
    end else begin
      checkOutput($sformatf("no_ready_%08h", addr), {31'h0, got}, 32'h0);
    end
    @(posedge clk);
    #1;
    bus.iomem_valid = 1'b0;
    bus.iomem_addr  = 32'h0;
    bus.iomem_wstrb = 4'h0;
    bus.iomem_wdata = 32'h0;
  endtask

  task automatic readReg(input logic [31:0] addr, input logic [31:0] exp_data);
    int lat;
    applyStimulus(addr, 4'h0, 32'h0, 1'b1, exp_data, 1'b1, 20, lat);
    checkOutput($sformatf("read_latency_%08h", addr), lat, 32'd1);
  endtask

  task automatic writeReg(input logic [31:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata);
    int lat;
    applyStimulus(addr, wstrb, wdata, 1'b0, 32'h0, 1'b1, 200, lat);
  endtask

  task automatic checkMosiByte(input string name, input int first, input logic [7:0] value);
    for (int i = 0; i < 8; i++) begin
      if (first + i < rise_mosi.size())
        checkOutput($sformatf("%s_bit%0d", name, 7 - i), {31'h0, rise_mosi[first + i]}, {31'h0, value[7 - i]});
      else
        checkOutput($sformatf("%s_bit%0d_missing", name, 7 - i), 32'h0, 32'h1);
    end
  endtask

  task automatic clearPins();
    rise_cycle.delete();
    rise_mosi.delete();
    busy_fall_cycle = -1;
  endtask

  initial begin
    int lat, e1, e2, fall1, waited;
    reset = 1'b1;
    bus.iomem_valid = 1'b0;
    bus.iomem_addr  = 32'h0;
    bus.iomem_wstrb = 4'h0;
    bus.iomem_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_ck", {31'h0, spi_ck}, 32'h0);
    checkOutput("reset_cs", {31'h0, spi_cs}, 32'h1);
    checkOutput("reset_mosi", {31'h0, spi_mosi}, 32'h0);
    checkOutput("reset_ready", {31'h0, bus.iomem_ready}, 32'h0);
    checkOutput("reset_rdata", bus.iomem_rdata, 32'h0);

    readReg(A_CTRL, 32'h0000_0001);
    readReg(A_STATUS, 32'h0);
    readReg(A_DATA, 32'h0);

    writeReg(A_CTRL, 4'b0010, 32'h0000_0100);
    readReg(A_CTRL, 32'h0000_0101);
    @(negedge clk);
    checkOutput("cs_asserted", {31'h0, spi_cs}, 32'h0);

    // div = 0, single byte in loopback
    writeReg(A_CTRL, 4'b0011, 32'h0000_0100);
    readReg(A_CTRL, 32'h0000_0100);
    clearPins();
    writeReg(A_DATA, 4'b0001, 32'h0000_00A5);
    e1 = last_ready_cycle;
    repeat (30) @(negedge clk);
    checkOutput("a5_rises", rise_cycle.size(), 32'd8);
    if (rise_cycle.size() > 0) checkOutput("a5_first_rise", rise_cycle[0], e1 + 1);
    checkOutput("a5_busy_fall", busy_fall_cycle, e1 + 16);
    checkMosiByte("a5_mosi", 0, 8'hA5);
    readReg(A_DATA, 32'h0000_00A5);

    // div = 2, back-to-back writes; the second stalls until the engine idles
    writeReg(A_CTRL, 4'b0011, 32'h0000_0102);
    clearPins();
    writeReg(A_DATA, 4'b0001, 32'h0000_003C);
    e1 = last_ready_cycle;
    applyStimulus(A_DATA, 4'b0001, 32'h0000_00C3, 1'b0, 32'h0, 1'b1, 100, lat);
    e2 = last_ready_cycle;
    fall1 = busy_fall_cycle;
    checkOutput("b2b_first_fall", fall1, e1 + 48);
    checkOutput("b2b_second_accept", e2, fall1 + 1);
    repeat (60) @(negedge clk);
    checkOutput("b2b_rises", rise_cycle.size(), 32'd16);
    if (rise_cycle.size() >= 9) begin
      checkOutput("b2b_first_rise", rise_cycle[0], e1 + 3);
      checkOutput("b2b_second_rise", rise_cycle[8], e2 + 3);
      checkOutput("b2b_gap", rise_cycle[8] - rise_cycle[7], 32'd7);
    end
    checkMosiByte("b2b_mosi_3c", 0, 8'h3C);
    checkMosiByte("b2b_mosi_c3", 8, 8'hC3);
    checkOutput("b2b_second_fall", busy_fall_cycle, e2 + 48);
    readReg(A_DATA, 32'h0000_00C3);

    // reads while busy complete at once and return the previous byte
    writeReg(A_DATA, 4'b0001, 32'h0000_005A);
    readReg(A_DATA, 32'h0000_00C3);
    readReg(A_STATUS, 32'h0000_0001);
    repeat (60) @(negedge clk);
    readReg(A_DATA, 32'h0000_005A);

    writeReg(A_STATUS, 4'b1111, 32'hFFFF_FFFF);
    readReg(A_STATUS, 32'h0);
    writeReg(A_RSVD, 4'b1111, 32'hFFFF_FFFF);
    readReg(A_RSVD, 32'h0);
    applyStimulus(A_OTHER, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0, 10, lat);
    applyStimulus(A_OTHER | 32'h4, 4'b0001, 32'h55, 1'b0, 32'h0, 1'b0, 10, lat);
    readReg(A_CTRL, 32'h0000_0102);

    // reset in the middle of a transfer
    clearPins();
    writeReg(A_DATA, 4'b0001, 32'h0000_0081);
    waited = 0;
    while (rise_cycle.size() < 4 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("fourth_rise_seen", {31'h0, rise_cycle.size() >= 4}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_ck", {31'h0, spi_ck}, 32'h0);
    checkOutput("abort_cs", {31'h0, spi_cs}, 32'h1);
    checkOutput("abort_mosi", {31'h0, spi_mosi}, 32'h0);
    checkOutput("abort_busy", {31'h0, dut.busy}, 32'h0);
    reset = 1'b0;
    readReg(A_DATA, 32'h0);
    readReg(A_CTRL, 32'h0000_0001);
    readReg(A_STATUS, 32'h0);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
